// File: rtl/alien_bomb_pkg.sv
// Shared playfield geometry for the alien formation, ship and projectiles.
package alien_bomb_pkg;

    localparam int GRID_ROWS = 5;
    localparam int GRID_COLS = 10;

    localparam int ALIEN_W  = 24;
    localparam int ALIEN_H  = 16;
    localparam int PITCH_X  = 32;
    localparam int PITCH_Y  = 24;

    localparam int SCREEN_H = 480;
    localparam int SHIP_ROW = 440;
    localparam int SHIP_W   = 32;
    localparam int SHIP_H   = 16;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Alive-mask bit position of the alien at (row, col); row 0 is the top row.
    function automatic logic [5:0] grid_index(input int row, input int col);
        return 6'(row * GRID_COLS + col);
    endfunction

endpackage

// File: rtl/bomb_lfsr.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), free-running every clock.
// Only the low nibble is exported: it seeds the candidate firing column.
module bomb_lfsr
    import alien_bomb_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] nibble
);

    // Right-shifting Galois form: taps for x^8+x^6+x^5+x^4+1.
    localparam logic [7:0] TAPS = 8'hB8;

    logic [7:0] value;

    // Shift every cycle; feedback bit folds into the tap positions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) value <= SEED;
        else     value <= (value >> 1) ^ (value[0] ? TAPS : 8'h00);
    end

    assign nibble = value[3:0];

endmodule

// File: rtl/alien_bomb.sv
// Alien bomb: periodically drops one bomb from the bottom-most living alien
// of a pseudo-random column and reports a strike on the player ship.
// Bomb_Row/Bomb_Col are only meaningful while Bomb_Onscreen is high; Ship_Hit
// is a single-cycle pulse coincident with Bomb_Onscreen falling.
module alien_bomb
    import alien_bomb_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Tick,
    input  logic [49:0] Aliens_Grid,
    input  logic [8:0]  Aliens_Row,
    input  logic [9:0]  Aliens_Col,
    input  logic [9:0]  Ship_Col,
    output logic [8:0]  Bomb_Row,
    output logic [9:0]  Bomb_Col,
    output logic        Bomb_Onscreen,
    output logic        Ship_Hit,
    output logic [1:0]  state_dbg
);

    localparam int BOMB_W        = 2;
    localparam int BOMB_H        = 8;
    localparam int BOMB_SPEED    = 4;
    localparam int FIRE_INTERVAL = 60;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        FALLING = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [5:0]  interval_cnt, interval_next;
    logic [3:0]  scan_cnt, scan_next;
    logic [3:0]  cand, cand_next;
    logic [8:0]  row_next;
    logic [9:0]  col_next;
    logic        on_next, hit_next;

    logic [3:0]  lfsr_nibble, lfsr_col;
    logic        col_alive;
    logic [2:0]  bottom_row;
    logic [10:0] bomb_top, bomb_bot, bomb_left, bomb_right, ship_left, ship_right;
    logic        hit, gone;

    bomb_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (Clk),
        .rst    (Reset),
        .nibble (lfsr_nibble)
    );

    assign lfsr_col  = (lfsr_nibble >= 4'd10) ? lfsr_nibble - 4'd10 : lfsr_nibble;
    assign state_dbg = state;

    // Bottom-most living alien of the candidate column; higher rows win.
    always_comb begin
        col_alive  = 1'b0;
        bottom_row = 3'd0;
        for (int r = 0; r < GRID_ROWS; r++) begin
            if (Aliens_Grid[grid_index(r, int'(cand))]) begin
                col_alive  = 1'b1;
                bottom_row = 3'(r);
            end
        end
    end

    // Collision and exit tests on the registered position, widened so nothing wraps.
    always_comb begin
        bomb_top   = {2'b00, Bomb_Row};
        bomb_bot   = bomb_top + 11'(BOMB_H);
        bomb_left  = {1'b0, Bomb_Col};
        bomb_right = bomb_left + 11'(BOMB_W);
        ship_left  = {1'b0, Ship_Col};
        ship_right = ship_left + 11'(SHIP_W);
        hit  = (bomb_bot > 11'(SHIP_ROW)) && (bomb_top < 11'(SHIP_ROW + SHIP_H)) &&
               (bomb_right > ship_left) && (bomb_left < ship_right);
        gone = bomb_bot > 11'(SCREEN_H);
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and datapath decisions for every FSM state.
    always_comb begin
        state_next    = state;
        interval_next = interval_cnt;
        scan_next     = scan_cnt;
        cand_next     = cand;
        row_next      = Bomb_Row;
        col_next      = Bomb_Col;
        on_next       = Bomb_Onscreen;
        hit_next      = 1'b0;
        case (state)
            IDLE: begin
                cand_next = lfsr_col;
                if (Tick) begin
                    if (interval_cnt == 6'(FIRE_INTERVAL - 1)) begin
                        interval_next = 6'd0;
                        scan_next     = 4'd0;
                        state_next    = SELECT;
                    end else begin
                        interval_next = interval_cnt + 6'd1;
                    end
                end
            end
            SELECT: begin
                if (col_alive) begin
                    col_next   = Aliens_Col + 10'(int'(cand) * PITCH_X) + 10'(ALIEN_W / 2 - BOMB_W / 2);
                    row_next   = Aliens_Row + 9'(int'(bottom_row) * PITCH_Y) + 9'(ALIEN_H);
                    on_next    = 1'b1;
                    scan_next  = 4'd0;
                    state_next = FALLING;
                end else begin
                    cand_next = (cand == 4'd9) ? 4'd0 : cand + 4'd1;
                    if (scan_cnt == 4'd9) begin
                        scan_next  = 4'd0;
                        state_next = IDLE;
                    end else begin
                        scan_next = scan_cnt + 4'd1;
                    end
                end
            end
            FALLING: begin
                if (hit) begin
                    hit_next   = 1'b1;
                    on_next    = 1'b0;
                    state_next = IDLE;
                end else if (gone) begin
                    on_next    = 1'b0;
                    state_next = IDLE;
                end else if (Tick) begin
                    row_next = Bomb_Row + 9'(BOMB_SPEED);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: counters, candidate column, bomb position and flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            interval_cnt  <= 6'd0;
            scan_cnt      <= 4'd0;
            cand          <= 4'd0;
            Bomb_Row      <= 9'd0;
            Bomb_Col      <= 10'd0;
            Bomb_Onscreen <= 1'b0;
            Ship_Hit      <= 1'b0;
        end else begin
            interval_cnt  <= interval_next;
            scan_cnt      <= scan_next;
            cand          <= cand_next;
            Bomb_Row      <= row_next;
            Bomb_Col      <= col_next;
            Bomb_Onscreen <= on_next;
            Ship_Hit      <= hit_next;
        end
    end

endmodule

// File: doc/alien_bomb.md
Name: alien_bomb

Overview:
Alien-side projectile. This is the reverse direction of the player bullet path: aliens fire, and the ship is the target. Periodically picks a pseudo-random column that still has a living alien, spawns one bomb under the bottom-most alive alien in that column, moves it down once per frame tick, and reports a hit on the player ship. At most one bomb is on screen at a time. The bomb consumes the same 50-bit alien grid and formation origin that the player-bullet logic uses.

Parameters:
ALIEN_W, 24, alien sprite width (px)
ALIEN_H, 16, alien sprite height (px)
PITCH_X, 32, column-to-column spacing (px)
PITCH_Y, 24, row-to-row spacing (px)
SHIP_ROW, 440, fixed top row of the ship
SHIP_W, 32, ship width
SHIP_H, 16, ship height
BOMB_W, 2, bomb width
BOMB_H, 8, bomb height
BOMB_SPEED, 4, rows moved per Tick
FIRE_INTERVAL, 60, Ticks spent in IDLE before a fire attempt
SCREEN_H, 480, visible rows
LFSR_SEED, 8'hA5, non-zero LFSR reset value

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Tick  in  1  one-cycle frame strobe; all motion and interval counting happen on it
Aliens_Grid  in  50  alive mask; bit r*10+c, with r=0 as the top row (0..4) and c=0 as the left column (0..9)
Aliens_Row  in  9  top row of the formation origin
Aliens_Col  in  10  left column of the formation origin
Ship_Col  in  10  left column of the ship
Bomb_Row  out  9  top row of the bomb
Bomb_Col  out  10  left column of the bomb
Bomb_Onscreen  out  1  high while a bomb is falling
Ship_Hit  out  1  one-cycle pulse when the bomb strikes the ship

Behaviour:
- Reset (async): state=IDLE; Bomb_Row=0, Bomb_Col=0, Bomb_Onscreen=0, Ship_Hit=0; interval counter=0; scan counter=0; LFSR=LFSR_SEED.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. Advances every Clk, independent of state.
- IDLE:
  - Counter increments on each Tick.
  - On the Tick that brings the counter to FIRE_INTERVAL: clear the counter, go to SELECT.
  - Load the candidate column from LFSR[3:0]; if the value is ≥10, subtract 10.
- SELECT (one column examined per Clk; Tick is ignored):
  - The bottom-most alive row r of the candidate column is found combinationally, with priority r=4 down to r=0.
  - Column has an alive alien: next edge loads
    - Bomb_Col = Aliens_Col + c*PITCH_X + ALIEN_W/2 - BOMB_W/2
    - Bomb_Row = Aliens_Row + r*PITCH_Y + ALIEN_H
    - Bomb_Onscreen=1, state → FALLING.
  - Column empty: candidate = (c+1) mod 10, scan counter +1.
  - After 10 empty columns (the whole grid is 0): return to IDLE, Bomb_Onscreen stays 0.
  - The grid is sampled live on every SELECT cycle.
- FALLING:
  - On each Tick: Bomb_Row += BOMB_SPEED.
  - Every cycle, evaluate on the registered position, using 11-bit unsigned arithmetic (no wrap):
    - hit = (Bomb_Row+BOMB_H > SHIP_ROW) && (Bomb_Row < SHIP_ROW+SHIP_H) && (Bomb_Col+BOMB_W > Ship_Col) && (Bomb_Col < Ship_Col+SHIP_W)
    - gone = (Bomb_Row+BOMB_H > SCREEN_H)
  - hit: next edge Ship_Hit=1 for exactly one cycle, Bomb_Onscreen=0, state → IDLE.
  - gone without hit: Bomb_Onscreen=0, state → IDLE, no pulse. If hit and gone are both true, hit wins.
  - A Tick arriving on the same cycle as hit or gone does not move the bomb.
- Bomb_Row/Bomb_Col hold their last value when off screen; consumers gate on Bomb_Onscreen.
- Formation motion after spawn does not affect the bomb.
- Reset asserted mid-fall: outputs go to reset values immediately; no Ship_Hit.

Decomposition:
- Shared package (shared with the player bullet and renderer): GRID_ROWS=5, GRID_COLS=10, grid bit-index function, ALIEN_W/H, PITCH_X/Y, SCREEN_H, SHIP_ROW/W/H.
- Local to this block: state encoding IDLE/SELECT/FALLING.
- One sub-module: bomb_lfsr (8-bit Galois LFSR with seed parameter).

Test Plan:
- Only grid bit 47 alive, Aliens_Row=40, Aliens_Col=100, Ship_Col=320; 60 Ticks → SELECT finds column 7 within ≤10 Clk; Bomb_Col=335, Bomb_Row=152, Bomb_Onscreen=1. After 71 further Ticks, Bomb_Row=436 and Ship_Hit pulses for one Clk; Bomb_Onscreen=0.
- Same setup with Ship_Col=0 → no hit; after 81 Ticks Bomb_Row=476 and Bomb_Onscreen drops; Ship_Hit never asserts.
- Aliens_Grid=0; 60 Ticks → SELECT lasts exactly 10 Clk, returns to IDLE, Bomb_Onscreen stays 0; a new attempt occurs 60 Ticks later.
- Grid all ones (50'h3FFFFFFFFFFFF) → the spawn row is always Aliens_Row+112. Over 20 fire cycles, every column in 0..9 is legal, and each chosen column matches the reference LFSR model.
- Assert Reset while Bomb_Row=300 → all outputs 0 asynchronously. After release, the next fire occurs exactly 60 Ticks later.
- Ship_Col=334 with the bomb at column 335: edge overlap counts as a hit. Ship_Col=337 (bomb right edge 337 not > 337): no hit.
